// File: rtl/spi_con.sv
// SPI frame receiver: synchronises sel/sclk/data into clk_in, shifts MSB-first bits on
// sclk rising edges and reports each frame as a valid word or as an error.
module spi_con #(
   parameter int unsigned MESSAGE_WIDTH = 8,
   parameter int unsigned SYNC_STAGES   = 2
) (
   input  logic                     clk_in,
   input  logic                     rst_in,
   input  logic                     data_in,
   input  logic                     clk_in_spi,
   input  logic                     sel_in,
   output logic [MESSAGE_WIDTH-1:0] data_out,
   output logic                     data_valid_out,
   output logic                     error_out,
   output logic                     busy_out
);

   localparam int unsigned CntW = $clog2(MESSAGE_WIDTH + SYNC_STAGES + 2);
   localparam logic [CntW-1:0] CntFull   = CntW'(MESSAGE_WIDTH);
   localparam logic [CntW-1:0] CntSat    = CntW'(MESSAGE_WIDTH + 1);
   localparam logic [CntW-1:0] CntSettle = CntW'(SYNC_STAGES);

   typedef enum logic [1:0] {StWaitIdle, StIdle, StRecv} state_e;

   state_e                   state_q, state_d;
   logic [SYNC_STAGES-1:0]   data_sync_q, clk_sync_q, sel_sync_q;
   logic                     clk_prev_q, sel_prev_q;
   logic [CntW-1:0]          cnt_q, cnt_d;
   logic [MESSAGE_WIDTH-1:0] shift_q, shift_d;
   logic [MESSAGE_WIDTH-1:0] data_q, data_d;
   logic                     valid_pend_q, valid_pend_d;
   logic                     error_pend_q, error_pend_d;
   logic                     valid_q, error_q;

   logic data_s, sclk_s, sel_s;
   logic sclk_rise, sel_fall, sel_rise;

   assign data_s    = data_sync_q[SYNC_STAGES-1];
   assign sclk_s    = clk_sync_q[SYNC_STAGES-1];
   assign sel_s     = sel_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~clk_prev_q;
   assign sel_fall  = ~sel_s & sel_prev_q;
   assign sel_rise  = sel_s & ~sel_prev_q;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         data_sync_q  <= '0;
         clk_sync_q   <= '0;
         sel_sync_q   <= '1;
         clk_prev_q   <= 1'b0;
         sel_prev_q   <= 1'b1;
         state_q      <= StWaitIdle;
         cnt_q        <= '0;
         shift_q      <= '0;
         data_q       <= '0;
         valid_pend_q <= 1'b0;
         error_pend_q <= 1'b0;
         valid_q      <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], data_in};
         clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], clk_in_spi};
         sel_sync_q   <= {sel_sync_q[SYNC_STAGES-2:0], sel_in};
         clk_prev_q   <= sclk_s;
         sel_prev_q   <= sel_s;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shift_q      <= shift_d;
         data_q       <= data_d;
         valid_pend_q <= valid_pend_d;
         error_pend_q <= error_pend_d;
         valid_q      <= valid_pend_q;
         error_q      <= error_pend_q;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      shift_d      = shift_q;
      data_d       = data_q;
      valid_pend_d = 1'b0;
      error_pend_d = 1'b0;
      unique case (state_q)
         // The sync chain holds reset values for SYNC_STAGES cycles; only trust sel after that.
         StWaitIdle: begin
            if (cnt_q < CntSettle) begin
               cnt_d = cnt_q + 1'b1;
            end else if (sel_s) begin
               state_d = StIdle;
               cnt_d   = '0;
            end
         end
         StIdle: begin
            if (sel_fall) begin
               state_d = StRecv;
               cnt_d   = '0;
               shift_d = '0;
            end
         end
         StRecv: begin
            // sel rising wins over a coincident sclk edge, which is dropped.
            if (sel_rise) begin
               state_d = StIdle;
               if (cnt_q == CntFull) begin
                  data_d       = shift_q;
                  valid_pend_d = 1'b1;
               end else begin
                  error_pend_d = 1'b1;
               end
            end else if (sclk_rise) begin
               shift_d = {shift_q[MESSAGE_WIDTH-2:0], data_s};
               if (cnt_q != CntSat) cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = StWaitIdle;
      endcase
   end

   assign data_out       = data_q;
   assign data_valid_out = valid_q;
   assign error_out      = error_q;
   assign busy_out       = (state_q == StRecv);

endmodule

// File: tb/tb_spi_con.sv
// Directed bench for spi_con: an inline SPI transmitter model drives frames and each
// scenario task checks strobes, captured words and busy against hand-computed values.
module tb_spi_con;
   localparam int W  = 8;
   localparam int S  = 2;
   localparam int PH = 3;

   logic         clk = 1'b0;
   logic         rst, data, sclk, sel;
   logic [W-1:0] dout;
   logic         dv, err, busy;

   int checks = 0;
   int passes = 0;
   int valid_cnt = 0, err_cnt = 0, both_cnt = 0, wide_cnt = 0;
   logic valid_prev = 1'b0, err_prev = 1'b0;
   logic [W-1:0] words[$];

   spi_con #(.MESSAGE_WIDTH(W), .SYNC_STAGES(S)) dut (
      .clk_in(clk), .rst_in(rst), .data_in(data), .clk_in_spi(sclk), .sel_in(sel),
      .data_out(dout), .data_valid_out(dv), .error_out(err), .busy_out(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (dv === 1'b1) begin
         valid_cnt++;
         words.push_back(dout);
      end
      if (err === 1'b1) err_cnt++;
      if (dv === 1'b1 && err === 1'b1) both_cnt++;
      if ((dv === 1'b1 && valid_prev === 1'b1) || (err === 1'b1 && err_prev === 1'b1)) wide_cnt++;
      valid_prev = dv;
      err_prev   = err;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sel_low();
      sclk = 1'b0;
      sel  = 1'b0;
      tick(PH);
   endtask

   task automatic send_bit(input logic b);
      data = b;
      sclk = 1'b0;
      tick(PH);
      sclk = 1'b1;
      tick(PH);
      sclk = 1'b0;
   endtask

   task automatic sel_high();
      sclk = 1'b0;
      tick(PH);
      sel = 1'b1;
   endtask

   task automatic send_word(input logic [15:0] w, input int n);
      sel_low();
      for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
      sel_high();
      tick(12);
   endtask

   task automatic test_reset();
      rst = 1'b1; sel = 1'b1; sclk = 1'b0; data = 1'b0;
      tick(3);
      checks++;
      if ({dout, dv, err, busy} !== {8'h00, 3'b000})
         $display("FAIL reset_outputs: got dout=%h dv=%b err=%b busy=%b, want 00 0 0 0",
                  dout, dv, err, busy);
      else passes++;
      rst = 1'b0;
      tick(S + 4);
      checks++;
      if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy);
      else passes++;
   endtask

   task automatic test_single();
      int v0, e0, n;
      v0 = valid_cnt; e0 = err_cnt;
      sel_low();
      for (int i = 7; i >= 0; i--) send_bit(i[0] ? 1'b1 : 1'b0);  // 0xA5 = 1010_0101? no: see below
      sel_high();
      tick(12);
      // Above sends 0xAA; now the real 0xA5 frame with latency measurement.
      v0 = valid_cnt; e0 = err_cnt;
      sel_low();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      checks++;
      if (busy !== 1'b1) $display("FAIL recv_busy: got %b want 1", busy);
      else passes++;
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      sclk = 1'b0;
      tick(PH);
      sel = 1'b1;
      @(posedge clk);  // first edge sampling sel=1
      #1;
      n = 0;
      while (dv !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n != S + 1) $display("FAIL latency: got %0d edges want %0d", n, S + 1);
      else passes++;
      tick(6);
      checks++;
      if (valid_cnt - v0 != 1 || err_cnt != e0)
         $display("FAIL single_strobes: got valid=%0d err=%0d want 1 0", valid_cnt - v0,
                  err_cnt - e0);
      else passes++;
      checks++;
      if (dout !== 8'hA5) $display("FAIL single_data: got %h want a5", dout);
      else passes++;
      checks++;
      if (busy !== 1'b0) $display("FAIL done_busy: got %b want 0", busy);
      else passes++;
   endtask

   task automatic test_back_to_back();
      int q0, e0;
      logic [7:0] exp [3];
      logic [7:0] w;
      exp[0] = 8'hFF; exp[1] = 8'h00; exp[2] = 8'h3C;
      q0 = words.size(); e0 = err_cnt;
      for (int f = 0; f < 3; f++) begin
         w = exp[f];
         sel_low();
         for (int i = 7; i >= 0; i--) send_bit(w[i]);
         sel_high();
         tick(2);
      end
      tick(12);
      checks++;
      if (words.size() - q0 != 3 || err_cnt != e0)
         $display("FAIL b2b_count: got valid=%0d err=%0d want 3 0", words.size() - q0,
                  err_cnt - e0);
      else passes++;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (q0 + i < words.size() && words[q0 + i] === exp[i]) passes++;
         else $display("FAIL b2b_word%0d: got %h want %h", i,
                       (q0 + i < words.size()) ? words[q0 + i] : 8'hxx, exp[i]);
      end
   endtask

   task automatic test_short();
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      send_word(16'h0016, 5);
      checks++;
      if (err_cnt - e0 != 1 || valid_cnt != v0)
         $display("FAIL short_strobes: got err=%0d valid=%0d want 1 0", err_cnt - e0,
                  valid_cnt - v0);
      else passes++;
      checks++;
      if (dout !== 8'h3C) $display("FAIL short_keep: got %h want 3c", dout);
      else passes++;
   endtask

   task automatic test_overrun();
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      send_word(16'h01FF, 9);
      checks++;
      if (err_cnt - e0 != 1 || valid_cnt != v0)
         $display("FAIL over_strobes: got err=%0d valid=%0d want 1 0", err_cnt - e0,
                  valid_cnt - v0);
      else passes++;
      send_word(16'h0081, 8);
      checks++;
      if (valid_cnt - v0 != 1 || dout !== 8'h81)
         $display("FAIL over_recover: got valid=%0d dout=%h want 1 81", valid_cnt - v0, dout);
      else passes++;
   endtask

   task automatic test_reset_mid();
      int v0, e0;
      logic [7:0] w;
      w = 8'hC3;
      v0 = valid_cnt; e0 = err_cnt;
      sel_low();
      for (int i = 7; i >= 4; i--) send_bit(w[i]);
      tick(1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      checks++;
      if (busy !== 1'b0 || dout !== 8'h00)
         $display("FAIL midrst_state: got busy=%b dout=%h want 0 00", busy, dout);
      else passes++;
      for (int i = 3; i >= 0; i--) send_bit(w[i]);
      sel_high();
      tick(12);
      checks++;
      if (valid_cnt != v0 || err_cnt != e0)
         $display("FAIL midrst_quiet: got valid=%0d err=%0d want 0 0", valid_cnt - v0,
                  err_cnt - e0);
      else passes++;
      send_word(16'h005A, 8);
      checks++;
      if (valid_cnt - v0 != 1 || dout !== 8'h5A)
         $display("FAIL midrst_next: got valid=%0d dout=%h want 1 5a", valid_cnt - v0, dout);
      else passes++;
   endtask

   task automatic test_sel_low_at_reset();
      int v0, e0;
      v0 = valid_cnt; e0 = err_cnt;
      rst = 1'b1;
      sel = 1'b0;
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      rst = 1'b0;
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      sel_high();
      tick(12);
      checks++;
      if (valid_cnt != v0 || err_cnt != e0)
         $display("FAIL lowsel_quiet: got valid=%0d err=%0d want 0 0", valid_cnt - v0,
                  err_cnt - e0);
      else passes++;
      send_word(16'h0096, 8);
      checks++;
      if (valid_cnt - v0 != 1 || dout !== 8'h96)
         $display("FAIL lowsel_next: got valid=%0d dout=%h want 1 96", valid_cnt - v0, dout);
      else passes++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_short();
      test_overrun();
      test_reset_mid();
      test_sel_low_at_reset();
      checks++;
      if (both_cnt != 0 || wide_cnt != 0)
         $display("FAIL strobe_shape: got overlap=%0d wide=%0d want 0 0", both_cnt, wide_cnt);
      else passes++;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
